ir_nec_decode: RTL and testbench
================================

IR_NEC_DECODE -- requirements
Module: ir_nec_decode

Interface
REQ-001 SHALL have parameter RELEASE_CYCLES, default 12_000_000 (120 ms at 100 MHz): idle cycles after the last accepted frame/repeat before a key is released.
REQ-002 SHALL have parameter ADDR_FILTER_EN, default 1'b1: when 1, only frames whose address equals MY_ADDR are accepted.
REQ-003 SHALL have parameter MY_ADDR, default 8'h10: the device address matched when filtering.
REQ-004 SHALL have port clk  input  1  the single system clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port burst  input  32  raw NEC frame from receiver: [31:24]=~addr, [23:16]=addr, [15:8]=cmd, [7:0]=~cmd.
REQ-007 SHALL have port ready  input  1  one-cycle strobe; burst valid this cycle.
REQ-008 SHALL have port rep  input  1  one-cycle strobe; NEC repeat code received.
REQ-009 SHALL have port addr  output  8  address of the current/last accepted key.
REQ-010 SHALL have port cmd  output  8  command of the current/last accepted key.
REQ-011 SHALL have port key_valid  output  1  one-cycle pulse per accepted new frame.
REQ-012 SHALL have port key_rpt  output  1  one-cycle pulse per accepted repeat code.
REQ-013 SHALL have port key_held  output  1  level, high while state is PRESSED.
REQ-014 SHALL have port key_rel  output  1  one-cycle pulse when a held key times out.
REQ-015 SHALL have port err  output  1  one-cycle pulse per rejected frame.
REQ-016 SHALL have port err_cnt  output  8  count of rejected frames, saturating at 8'hFF.

Function
REQ-017 SHALL validate a frame when ready=1: burst[23:16]==~burst[31:24] AND burst[15:8]==~burst[7:0] AND (ADDR_FILTER_EN==0 OR burst[23:16]==MY_ADDR).
REQ-018 SHALL implement two states, IDLE and PRESSED; reset state IDLE.
REQ-019 SHALL, on a valid frame in either state: load addr/cmd, pulse key_valid, reload the timer to 0, go to PRESSED; all outputs registered, visible the cycle after ready.
REQ-020 SHALL, on rep=1 in PRESSED: pulse key_rpt, reload timer to 0, leave addr/cmd unchanged.
REQ-021 SHALL ignore rep=1 in IDLE (orphan repeat): no pulse, no error, no count.
REQ-022 SHALL, on an invalid frame: pulse err, increment err_cnt (hold at 8'hFF), leave state, addr, cmd and timer unchanged; an address-filter mismatch counts as invalid.
REQ-023 SHALL, in PRESSED, increment a 32-bit timer each cycle with no event; when timer reaches RELEASE_CYCLES-1 pulse key_rel, return to IDLE, key_held low the same cycle key_rel is high.
REQ-024 SHALL give ready priority when ready and rep are both 1 in one cycle; rep is discarded.
REQ-025 SHALL, if a valid frame or repeat arrives in the same cycle the timer would expire, service the event and suppress key_rel.
REQ-026 SHALL hold addr/cmd after release until the next valid frame.
REQ-027 SHALL never assert key_valid, key_rpt, key_rel, err for more than one cycle per event.

Reset
REQ-028 SHALL, while rst_n=0, asynchronously force state IDLE, timer 0, addr 8'h00, cmd 8'h00, err_cnt 8'h00, and key_valid, key_rpt, key_held, key_rel, err all 0.
REQ-029 SHALL discard any frame/repeat in progress when reset asserts mid-PRESSED; no key_rel issued on reset.

Verification (RELEASE_CYCLES=100 for simulation)
REQ-030 SHALL cover: ready with burst=32'hEF10_40BF -> next cycle key_valid=1, addr=8'h10, cmd=8'h40, key_held=1; no further input -> key_rel pulse 100 cycles later, key_held=0.
REQ-031 SHALL cover: valid press then rep every 50 cycles x3 -> three key_rpt pulses, no key_rel until 100 idle cycles after the last rep.
REQ-032 SHALL cover: burst=32'hEF10_4040 (bad ~cmd) -> err pulse, err_cnt=1, key_valid=0, state unchanged; 300 bad frames -> err_cnt=8'hFF.
REQ-033 SHALL cover: ADDR_FILTER_EN=1, burst=32'hDF20_40BF -> err pulse; ADDR_FILTER_EN=0, same burst -> key_valid, addr=8'h20.
REQ-034 SHALL cover: rep in IDLE -> no output change; ready and rep same cycle -> key_valid only; event at timer=99 -> no key_rel.
REQ-035 SHALL cover: rst_n low while PRESSED with cmd=8'h40 -> immediately key_held=0, addr=cmd=err_cnt=0, no key_rel after release of reset.

Source files
------------

// File: rtl/ir_nec_decode.sv
// NEC IR frame decoder: validates raw 32-bit frames, tracks a pressed key,
// reports repeats and releases a held key after an idle timeout.
//
// Handshake: ready and rep are single-cycle strobes with no back-pressure.
// burst is sampled only in a cycle where ready=1. ready wins over rep when
// both are high. Every output is registered and reflects the event one cycle
// after the strobe.
module ir_nec_decode #(
  parameter int unsigned RELEASE_CYCLES = 12_000_000,
  parameter logic        ADDR_FILTER_EN = 1'b1,
  parameter logic [7:0]  MY_ADDR        = 8'h10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] burst,
  input  logic        ready,
  input  logic        rep,
  output logic [7:0]  addr,
  output logic [7:0]  cmd,
  output logic        key_valid,
  output logic        key_rpt,
  output logic        key_held,
  output logic        key_rel,
  output logic        err,
  output logic [7:0]  err_cnt
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESSED = 1'b1
  } state_t;

  // Timer value on which the release fires (timer counts quiet cycles from 0).
  localparam logic [31:0] REL_LAST = 32'(RELEASE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        key_valid_q, key_valid_d;
  logic        key_rpt_q, key_rpt_d;
  logic        key_rel_q, key_rel_d;
  logic        err_q, err_d;
  logic        frame_ok;

  // Frame check: both complement pairs must match, plus optional address filter.
  always_comb begin
    frame_ok = (burst[23:16] == ~burst[31:24]) &&
               (burst[15:8]  == ~burst[7:0])   &&
               ((ADDR_FILTER_EN == 1'b0) || (burst[23:16] == MY_ADDR));
  end

  // Next-state and output logic; a frame strobe takes priority over everything.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    addr_d      = addr_q;
    cmd_d       = cmd_q;
    err_cnt_d   = err_cnt_q;
    key_valid_d = 1'b0;
    key_rpt_d   = 1'b0;
    key_rel_d   = 1'b0;
    err_d       = 1'b0;

    if (ready) begin
      if (frame_ok) begin
        addr_d      = burst[23:16];
        cmd_d       = burst[15:8];
        key_valid_d = 1'b1;
        timer_d     = '0;
        state_d     = PRESSED;
      end else begin
        // Rejected frame freezes state, key and timer; only the error path moves.
        err_d = 1'b1;
        if (err_cnt_q != 8'hFF) begin
          err_cnt_d = err_cnt_q + 8'd1;
        end
      end
    end else if (state_q == PRESSED) begin
      if (rep) begin
        key_rpt_d = 1'b1;
        timer_d   = '0;
      end else if (timer_q == REL_LAST) begin
        key_rel_d = 1'b1;
        timer_d   = '0;
        state_d   = IDLE;
      end else begin
        timer_d = timer_q + 32'd1;
      end
    end
  end

  // State and output registers; reset clears everything without a release pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      addr_q      <= '0;
      cmd_q       <= '0;
      err_cnt_q   <= '0;
      key_valid_q <= 1'b0;
      key_rpt_q   <= 1'b0;
      key_rel_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      addr_q      <= addr_d;
      cmd_q       <= cmd_d;
      err_cnt_q   <= err_cnt_d;
      key_valid_q <= key_valid_d;
      key_rpt_q   <= key_rpt_d;
      key_rel_q   <= key_rel_d;
      err_q       <= err_d;
    end
  end

  // key_held is the FSM state itself, so it doubles as the state debug view.
  always_comb begin
    addr      = addr_q;
    cmd       = cmd_q;
    err_cnt   = err_cnt_q;
    key_valid = key_valid_q;
    key_rpt   = key_rpt_q;
    key_rel   = key_rel_q;
    err       = err_q;
    key_held  = (state_q == PRESSED);
  end

endmodule

// File: tb/tb_ir_nec_decode.sv
// Bench for ir_nec_decode: two instances (address filter on / off) share one
// stimulus stream and are compared every cycle against a key-level model.
module tb_ir_nec_decode;

  localparam int REL = 100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] burst = '0;
  logic        ready = 1'b0;
  logic        rep = 1'b0;

  logic [7:0] addr_f, cmd_f, ec_f, addr_n, cmd_n, ec_n;
  logic kv_f, kr_f, kh_f, krel_f, e_f;
  logic kv_n, kr_n, kh_n, krel_n, e_n;

  ir_nec_decode #(.RELEASE_CYCLES(REL), .ADDR_FILTER_EN(1'b1), .MY_ADDR(8'h10)) dut (
    .clk(clk), .rst_n(rst_n), .burst(burst), .ready(ready), .rep(rep),
    .addr(addr_f), .cmd(cmd_f), .key_valid(kv_f), .key_rpt(kr_f),
    .key_held(kh_f), .key_rel(krel_f), .err(e_f), .err_cnt(ec_f));

  ir_nec_decode #(.RELEASE_CYCLES(REL), .ADDR_FILTER_EN(1'b0), .MY_ADDR(8'h10)) dut_nf (
    .clk(clk), .rst_n(rst_n), .burst(burst), .ready(ready), .rep(rep),
    .addr(addr_n), .cmd(cmd_n), .key_valid(kv_n), .key_rpt(kr_n),
    .key_held(kh_n), .key_rel(krel_n), .err(e_n), .err_cnt(ec_n));

  // ---------------- behavioural model ----------------
  // A key is either held or not; "quiet" counts cycles with nothing accepted
  // since the last press/repeat, and the key is released on the REL-th one.
  typedef struct packed {
    logic        held;
    logic [31:0] quiet;
    logic [7:0]  a;
    logic [7:0]  c;
    logic [7:0]  ec;
    logic        kv;
    logic        kr;
    logic        krel;
    logic        e;
  } m_t;

  m_t m_f, m_n;
  int n_cmp = 0;
  int n_bad = 0;

  function automatic m_t model_step(m_t s, bit filt, logic [31:0] b, logic r, logic p);
    m_t  n;
    bit  ok;
    n = s;
    n.kv = 0; n.kr = 0; n.krel = 0; n.e = 0;
    ok = ((b[23:16] ^ b[31:24]) == 8'hFF) && ((b[15:8] ^ b[7:0]) == 8'hFF) &&
         (!filt || b[23:16] == 8'h10);
    if (r) begin
      if (ok) begin
        n.a = b[23:16]; n.c = b[15:8]; n.kv = 1; n.held = 1; n.quiet = 0;
      end else begin
        n.e = 1;
        n.ec = (s.ec == 8'hFF) ? 8'hFF : s.ec + 8'd1;
      end
    end else if (s.held && p) begin
      n.kr = 1; n.quiet = 0;
    end else if (s.held) begin
      n.quiet = s.quiet + 1;
      if (n.quiet == REL) begin
        n.held = 0; n.krel = 1; n.quiet = 0;
      end
    end
    return n;
  endfunction

  function automatic logic [28:0] view(m_t s);
    return {s.a, s.c, s.ec, s.kv, s.kr, s.held, s.krel, s.e};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_f <= '0;
      m_n <= '0;
    end else begin
      m_f <= model_step(m_f, 1'b1, burst, ready, rep);
      m_n <= model_step(m_n, 1'b0, burst, ready, rep);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [28:0] got_f, got_n;
    got_f = {addr_f, cmd_f, ec_f, kv_f, kr_f, kh_f, krel_f, e_f};
    got_n = {addr_n, cmd_n, ec_n, kv_n, kr_n, kh_n, krel_n, e_n};
    n_cmp += 2;
    if (got_f !== view(m_f)) begin
      n_bad++;
      $display("FAIL cycle_filt t=%0t got=%h exp=%h", $time, got_f, view(m_f));
    end
    if (got_n !== view(m_n)) begin
      n_bad++;
      $display("FAIL cycle_nofilt t=%0t got=%h exp=%h", $time, got_n, view(m_n));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Apply inputs for one clock; returns #1 after the following negedge.
  task automatic step(input logic r, input logic p, input logic [31:0] b);
    ready = r; rep = p; burst = b;
    @(posedge clk);
    @(negedge clk);
    #1;
    ready = 1'b0; rep = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_idle(input int n, output int first_rel, output int n_rel,
                          output logic held_at_rel);
    first_rel = -1; n_rel = 0; held_at_rel = 1'bx;
    for (int k = 1; k <= n; k++) begin
      step(1'b0, 1'b0, 32'h0);
      if (krel_f) begin
        n_rel++;
        if (first_rel < 0) begin
          first_rel = k;
          held_at_rel = kh_f;
        end
      end
    end
  endtask

  function automatic logic [31:0] mk(logic [7:0] a, logic [7:0] c);
    return {~a, a, c, ~c};
  endfunction

  // ---------------- directed + random stimulus ----------------
  initial begin
    int   fr, nr, tot, rpt;
    logic hr;
    logic [31:0] b;
    logic r, p;

    @(negedge clk); #1;
    chk("reset_held", {31'd0, kh_f}, 32'd0);
    chk("reset_errcnt", {24'd0, ec_f}, 32'd0);
    rst_n = 1'b1;

    // Press and timeout release.
    step(1'b1, 1'b0, 32'hEF10_40BF);
    chk("press_kv", {31'd0, kv_f}, 32'd1);
    chk("press_addr", {24'd0, addr_f}, 32'h10);
    chk("press_cmd", {24'd0, cmd_f}, 32'h40);
    chk("press_held", {31'd0, kh_f}, 32'd1);
    run_idle(150, fr, nr, hr);
    chk("release_delay", fr, 100);
    chk("release_held_low", {31'd0, hr}, 32'd0);
    chk("release_hold_cmd", {24'd0, cmd_f}, 32'h40);

    // Repeats every 50 cycles keep the key held.
    step(1'b1, 1'b0, 32'hEF10_40BF);
    tot = 0; rpt = 0;
    for (int i = 0; i < 3; i++) begin
      run_idle(49, fr, nr, hr);
      tot += nr;
      step(1'b0, 1'b1, 32'h0);
      rpt += kr_f;
    end
    chk("rpt_count", rpt, 3);
    chk("rpt_no_rel", tot, 0);
    run_idle(150, fr, nr, hr);
    chk("rpt_release_delay", fr, 100);

    // Bad frames and error counter saturation.
    do_reset();
    step(1'b1, 1'b0, 32'hEF10_4040);
    chk("bad_err", {31'd0, e_f}, 32'd1);
    chk("bad_errcnt", {24'd0, ec_f}, 32'd1);
    chk("bad_kv", {31'd0, kv_f}, 32'd0);
    chk("bad_held", {31'd0, kh_f}, 32'd0);
    for (int i = 0; i < 300; i++) step(1'b1, 1'b0, 32'hEF10_4040);
    chk("errcnt_sat", {24'd0, ec_f}, 32'hFF);

    // Address filter.
    step(1'b1, 1'b0, 32'hDF20_40BF);
    chk("filt_err", {31'd0, e_f}, 32'd1);
    chk("filt_kv", {31'd0, kv_f}, 32'd0);
    chk("nofilt_kv", {31'd0, kv_n}, 32'd1);
    chk("nofilt_addr", {24'd0, addr_n}, 32'h20);

    // Orphan repeat, ready+rep collision, event on the last timer cycle.
    do_reset();
    step(1'b0, 1'b1, 32'h0);
    chk("orphan_rpt", {31'd0, kr_f}, 32'd0);
    chk("orphan_held", {31'd0, kh_f}, 32'd0);
    step(1'b1, 1'b1, mk(8'h10, 8'h22));
    chk("collide_kv", {31'd0, kv_f}, 32'd1);
    chk("collide_rpt", {31'd0, kr_f}, 32'd0);
    run_idle(99, fr, nr, hr);
    chk("edge_no_early_rel", nr, 0);
    step(1'b0, 1'b1, 32'h0);
    chk("edge_rpt", {31'd0, kr_f}, 32'd1);
    chk("edge_no_rel", {31'd0, krel_f}, 32'd0);

    // Reset while pressed.
    step(1'b1, 1'b0, 32'hEF10_40BF);
    step(1'b1, 1'b0, 32'hEF10_4040);
    run_idle(10, fr, nr, hr);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_held", {31'd0, kh_f}, 32'd0);
    chk("rst_addr", {24'd0, addr_f}, 32'd0);
    chk("rst_cmd", {24'd0, cmd_f}, 32'd0);
    chk("rst_errcnt", {24'd0, ec_f}, 32'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    run_idle(150, fr, nr, hr);
    chk("rst_no_rel", nr, 0);

    // Random traffic; the per-cycle compare does the checking.
    for (int seg = 0; seg < 10; seg++) begin
      int fr_rate, rp_rate, len;
      fr_rate = $urandom_range(4, 60);
      rp_rate = $urandom_range(10, 80);
      len = $urandom_range(100, 250);
      if (seg == 5) do_reset();
      for (int i = 0; i < len; i++) begin
        r = ($urandom_range(0, fr_rate - 1) == 0);
        p = ($urandom_range(0, rp_rate - 1) == 0);
        case ($urandom_range(0, 3))
          0: b = mk(8'h10, 8'($urandom));
          1: b = mk(8'($urandom), 8'($urandom));
          2: b = $urandom;
          default: b = mk(8'h10, 8'($urandom_range(0, 3)));
        endcase
        step(r, p, b);
      end
    end
    run_idle(120, fr, nr, hr);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
